// File: rtl/topk_pkg.sv
// -----------------------------------------------------------------------------
// topk_pkg
// Shared types and helpers for the top-K stream tracker and the CAS-stage tests.
//   state_e : tracker FSM states (COLLECT, DRAIN)
//   slot_t  : one retained element {valid, data[, idx]}
//   gt()    : strict greater-than, unsigned or two's-complement signed
// Element width (TOPK_DW) and frame position width (TOPK_IDXW) live here so that
// the slot struct, the interface and the comparator all agree.
// Optional feature macro: TOPK_IDX_EN (adds the idx field to slot_t).
// -----------------------------------------------------------------------------
package topk_pkg;

  localparam int TOPK_DW   = 8;
  localparam int TOPK_IDXW = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [TOPK_DW-1:0]   data;
`ifdef TOPK_IDX_EN
    logic [TOPK_IDXW-1:0] idx;
`endif
  } slot_t;

  // Strict compare keeps insertion stable: an equal newcomer lands behind
  // the elements already held.
  function automatic logic gt(input logic [TOPK_DW-1:0] a,
                              input logic [TOPK_DW-1:0] b,
                              input logic               signed_mode);
    if (signed_mode) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

endpackage

// File: rtl/topk_stream_tracker_if.sv
// -----------------------------------------------------------------------------
// topk_stream_tracker_if
// Stream bundle of the top-K tracker.
//   sign_ctrl_i                        compare mode (0 unsigned, 1 signed)
//   in_valid_i/in_ready_o/in_data_i/in_last_i      input element stream
//   out_valid_o/out_ready_i/out_data_o/out_last_o  result stream
//   out_cnt_o                          number of results in the current drain
//   out_idx_o                          frame position of out_data_o (TOPK_IDX_EN)
// Modports: slave = tracker side, master = producer/consumer side.
// Optional feature macro: TOPK_IDX_EN.
// -----------------------------------------------------------------------------
interface topk_stream_tracker_if #(
  parameter int K = 4
);
  import topk_pkg::*;

  localparam int CNTW = $clog2(K + 1);

  logic                 sign_ctrl_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [TOPK_DW-1:0]   in_data_i;
  logic                 in_last_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [TOPK_DW-1:0]   out_data_o;
  logic                 out_last_o;
  logic [CNTW-1:0]      out_cnt_o;
`ifdef TOPK_IDX_EN
  logic [TOPK_IDXW-1:0] out_idx_o;
`endif

  modport slave (
    input  sign_ctrl_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o, out_cnt_o
`ifdef TOPK_IDX_EN
    , output out_idx_o
`endif
  );

  modport master (
    output sign_ctrl_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o, out_cnt_o
`ifdef TOPK_IDX_EN
    , input out_idx_o
`endif
  );

endinterface

// File: rtl/topk_slot_cmp.sv
// -----------------------------------------------------------------------------
// topk_slot_cmp
// Per-slot comparator: is_greater = slot empty OR new element > slot content.
// An empty slot behaves as -infinity so new elements always fall into it.
//   new_data    in   incoming element
//   slot_valid  in   slot holds an element
//   slot_data   in   slot element
//   signed_mode in   compare as two's-complement
//   is_greater  out  new element belongs at or above this slot
// -----------------------------------------------------------------------------
module topk_slot_cmp
  import topk_pkg::*;
(
  input  logic [TOPK_DW-1:0] new_data,
  input  logic               slot_valid,
  input  logic [TOPK_DW-1:0] slot_data,
  input  logic               signed_mode,
  output logic               is_greater
);

  assign is_greater = !slot_valid || gt(new_data, slot_data, signed_mode);

endmodule

// File: rtl/topk_stream_tracker.sv
// -----------------------------------------------------------------------------
// topk_stream_tracker
// Keeps the K largest elements of a frame in a descending register array via
// single-cycle insertion, then drains them largest first and rearms.
//   clk_i   in  clock, rising edge
//   rstn_i  in  synchronous active-low reset
//   bus     slave modport of topk_stream_tracker_if (input and result streams)
// Parameter K: number of retained maxima (K >= 1).
// Optional feature macro: TOPK_IDX_EN -- each slot also carries the frame
// position of its element and out_idx_o presents it while draining.
// -----------------------------------------------------------------------------
module topk_stream_tracker
  import topk_pkg::*;
#(
  parameter int K = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  topk_stream_tracker_if.slave bus
);

  localparam int CNTW = $clog2(K + 1);

  state_e          state_reg;
  slot_t           slot_reg  [K];
  slot_t           slot_next [K];
  slot_t           new_slot;
  logic [K-1:0]    gt_vec;
  logic [CNTW-1:0] count_reg;
  logic [CNTW-1:0] rd_idx_reg;
  logic            sign_reg;
  logic            sign_eff;
  logic            accept;
  logic            rd_last;
`ifdef TOPK_IDX_EN
  logic [TOPK_IDXW-1:0] pos_reg;
`endif

  assign accept  = (state_reg == COLLECT) && bus.in_valid_i;
  // count is zero only before the first accept of a frame, so the live
  // sign_ctrl_i governs that first insertion and the latched copy the rest.
  assign sign_eff = (count_reg == '0) ? bus.sign_ctrl_i : sign_reg;
  assign rd_last  = (rd_idx_reg == count_reg - CNTW'(1));

  always_comb begin
    new_slot       = '0;
    new_slot.valid = 1'b1;
    new_slot.data  = bus.in_data_i;
`ifdef TOPK_IDX_EN
    new_slot.idx   = pos_reg;
`endif
  end

  // gt_vec is monotone (false above the insertion point, true at and below),
  // so each slot either keeps its value, takes the newcomer, or takes its
  // upper neighbour; the element shifted out of slot K-1 is dropped.
  for (genvar gi = 0; gi < K; gi++) begin : g_slot
    topk_slot_cmp u_cmp (
      .new_data    (bus.in_data_i),
      .slot_valid  (slot_reg[gi].valid),
      .slot_data   (slot_reg[gi].data),
      .signed_mode (sign_eff),
      .is_greater  (gt_vec[gi])
    );
    if (gi == 0) begin : g_head
      assign slot_next[gi] = gt_vec[gi] ? new_slot : slot_reg[gi];
    end else begin : g_body
      assign slot_next[gi] = gt_vec[gi-1] ? slot_reg[gi-1] :
                             gt_vec[gi]   ? new_slot       : slot_reg[gi];
    end
  end

  assign bus.in_ready_o  = (state_reg == COLLECT);
  assign bus.out_valid_o = (state_reg == DRAIN);

  // Result outputs read straight from registers and are forced to zero
  // outside DRAIN, so they cannot move while a result is stalled.
  always_comb begin
    bus.out_data_o = '0;
    bus.out_last_o = 1'b0;
    bus.out_cnt_o  = '0;
`ifdef TOPK_IDX_EN
    bus.out_idx_o  = '0;
`endif
    if (state_reg == DRAIN) begin
      bus.out_last_o = rd_last;
      bus.out_cnt_o  = count_reg;
      for (int i = 0; i < K; i++) begin
        if (rd_idx_reg == CNTW'(i)) begin
          bus.out_data_o = slot_reg[i].data;
`ifdef TOPK_IDX_EN
          bus.out_idx_o  = slot_reg[i].idx;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_reg  <= COLLECT;
      for (int i = 0; i < K; i++) slot_reg[i] <= '0;
      count_reg  <= '0;
      rd_idx_reg <= '0;
      sign_reg   <= 1'b0;
`ifdef TOPK_IDX_EN
      pos_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            for (int i = 0; i < K; i++) slot_reg[i] <= slot_next[i];
            if (count_reg != CNTW'(K)) count_reg <= count_reg + CNTW'(1);
            if (count_reg == '0) sign_reg <= bus.sign_ctrl_i;
`ifdef TOPK_IDX_EN
            pos_reg <= pos_reg + TOPK_IDXW'(1);
`endif
            if (bus.in_last_i) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.out_ready_i) begin
            if (rd_last) begin
              for (int i = 0; i < K; i++) slot_reg[i] <= '0;
              count_reg  <= '0;
              rd_idx_reg <= '0;
`ifdef TOPK_IDX_EN
              pos_reg    <= '0;
`endif
              state_reg  <= COLLECT;
            end else begin
              rd_idx_reg <= rd_idx_reg + CNTW'(1);
            end
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

endmodule
